// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file command sequencer: opcodes,
// source-select codes, fixed control words and control-word field layout.
package rf_seq_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_MOV    = 3'b010;
    localparam logic [2:0] OP_SWAP   = 3'b011;
    localparam logic [2:0] OP_BCAST  = 3'b100;
    localparam logic [2:0] OP_ROT    = 3'b101;
    localparam logic [2:0] OP_CLRALL = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    // Source-select codes: 011 picks the data bus, 1kk picks register Rkk.
    // Fields of registers that are not written are parked at 111.
    localparam logic [2:0] SEL_DATA = 3'b011;
    localparam logic [2:0] SEL_KEEP = 3'b111;

    // Control-word layout: four 3-bit select fields, then four write enables.
    localparam int FIELD_W    = 3;
    localparam int R0_SEL_LSB = 13;
    localparam int R1_SEL_LSB = 10;
    localparam int R2_SEL_LSB = 7;
    localparam int R3_SEL_LSB = 4;
    localparam int WE_LSB     = 0;

    localparam logic [15:0] IDLE_WORD = {SEL_KEEP, SEL_KEEP, SEL_KEEP, SEL_KEEP, 4'h0};

    // One rotate step: R0<-R3, R1<-R0, R2<-R1, R3<-R2, all four written.
    localparam logic [15:0] ROT_WORD = {3'b111, 3'b100, 3'b101, 3'b110, 4'hF};

    // Sequencer FSM states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ROT  = 1'b1;

    function automatic logic [2:0] sel_r(input logic [1:0] k);
        return {1'b1, k};
    endfunction

    function automatic int sel_lsb(input logic [1:0] k);
        case (k)
            2'd0:    return R0_SEL_LSB;
            2'd1:    return R1_SEL_LSB;
            2'd2:    return R2_SEL_LSB;
            default: return R3_SEL_LSB;
        endcase
    endfunction

    // Replace the select field of register k in a control word.
    function automatic logic [15:0] put_sel(input logic [15:0] word,
                                            input logic [1:0]  k,
                                            input logic [2:0]  sel);
        logic [15:0] r;
        r = word;
        r[sel_lsb(k) +: FIELD_W] = sel;
        return r;
    endfunction

    // Set the write enable of register k in a control word.
    function automatic logic [15:0] set_we(input logic [15:0] word,
                                           input logic [1:0]  k);
        logic [15:0] r;
        r = word;
        r[WE_LSB + int'(k)] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rf_cmd_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy count.
// Pushes while full and pops while empty are ignored.
module rf_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == OCC_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Next storage contents, pointers and occupancy for this cycle's push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_cmd_sequencer.sv
// Command-level controller for a 4 x 16-bit register file. Queues
// register-transfer commands and turns each into registered control-word /
// data-bus cycles, with a done pulse on the last cycle of every command.
module rf_cmd_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int QDEPTH = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_rd,
    input  logic [1:0]        cmd_rs,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [15:0]       ctrl,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    localparam int CMD_W = 3 + 2 + 2 + DATA_W;

    logic [CMD_W-1:0]  fifo_wr;
    logic [CMD_W-1:0]  fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    logic [2:0]        head_op;
    logic [1:0]        head_rd;
    logic [1:0]        head_rs;
    logic [DATA_W-1:0] head_imm;
    logic [CNT_W-1:0]  rot_n;

    logic [15:0]       op_word;
    logic              op_sets_data;
    logic [DATA_W-1:0] op_data;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;

    // Ready comes from the registered full flag, so a pop on the same edge
    // never opens a slot for a push on that edge.
    assign cmd_ready = !fifo_full && !rst;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_wr   = {cmd_op, cmd_rd, cmd_rs, cmd_imm};

    assign head_op  = fifo_rd[CMD_W-1 -: 3];
    assign head_rd  = fifo_rd[DATA_W+3 -: 2];
    assign head_rs  = fifo_rd[DATA_W+1 -: 2];
    assign head_imm = fifo_rd[DATA_W-1:0];
    assign rot_n    = head_imm[CNT_W-1:0];

    rf_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Encode the queue head into its control word and any data-bus update.
    always_comb begin
        op_word      = IDLE_WORD;
        op_sets_data = 1'b0;
        op_data      = data_q;
        case (head_op)
            OP_LOAD: begin
                op_word      = set_we(put_sel(IDLE_WORD, head_rd, SEL_DATA), head_rd);
                op_sets_data = 1'b1;
                op_data      = head_imm;
            end
            OP_MOV: begin
                op_word = set_we(put_sel(IDLE_WORD, head_rd, sel_r(head_rs)), head_rd);
            end
            OP_SWAP: begin
                op_word = put_sel(IDLE_WORD, head_rd, sel_r(head_rs));
                op_word = put_sel(op_word, head_rs, sel_r(head_rd));
                op_word = set_we(set_we(op_word, head_rd), head_rs);
            end
            OP_BCAST: begin
                for (int k = 0; k < 4; k++) begin
                    if (2'(k) != head_rs) begin
                        op_word = set_we(put_sel(op_word, 2'(k), sel_r(head_rs)), 2'(k));
                    end
                end
            end
            OP_ROT: begin
                op_word = (rot_n == '0) ? IDLE_WORD : ROT_WORD;
            end
            OP_CLRALL: begin
                for (int k = 0; k < 4; k++) begin
                    op_word = set_we(put_sel(op_word, 2'(k), SEL_DATA), 2'(k));
                end
                op_sets_data = 1'b1;
                op_data      = '0;
            end
            OP_NOP, OP_RSVD: begin
                op_word = IDLE_WORD;
            end
            default: begin
                op_word = IDLE_WORD;
            end
        endcase
    end

    // Issue FSM: pop one command per idle cycle, stretch ROT over n cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = IDLE_WORD;
        data_d   = data_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    ctrl_d   = op_word;
                    if (head_op == OP_ROT && rot_n > CNT_W'(1)) begin
                        state_d = ST_ROT;
                        cnt_d   = rot_n - CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                    if (op_sets_data) begin
                        data_d = op_data;
                    end
                end
            end
            ST_ROT: begin
                ctrl_d = ROT_WORD;
                if (cnt_q <= CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output and FSM registers; reset drops any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= IDLE_WORD;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign ctrl = ctrl_q;
    assign data = data_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// Bench for rf_cmd_sequencer: directed scenarios followed by random command
// traffic, all compared against a cycle-stream reference model.
module tb_rf_cmd_sequencer;

    localparam int DATA_W = 16;
    localparam int QDEPTH = 2;
    localparam int CNT_W  = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op    = '0;
    logic [1:0]  cmd_rd    = '0;
    logic [1:0]  cmd_rs    = '0;
    logic [15:0] cmd_imm   = '0;
    logic        cmd_ready;
    logic [15:0] ctrl;
    logic [15:0] data;
    logic        busy;
    logic        done;

    rf_cmd_sequencer #(
        .DATA_W (DATA_W),
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs    (cmd_rs),
        .cmd_imm   (cmd_imm),
        .ctrl      (ctrl),
        .data      (data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One expected output cycle of the register-file interface.
    typedef struct {
        logic [15:0] ctrl;
        bit          set_data;
        logic [15:0] dval;
        bit          done;
        bit          first;
    } entry_t;

    entry_t      sched[$];
    int          occ;
    logic [15:0] exp_data;
    bit          rot_active;
    bit          accepted;
    int          checks;
    int          errors;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expand a command into the cycles it should produce, from the
    // register-transfer meaning of each opcode.
    task automatic expand(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                          input logic [15:0] imm);
        entry_t     e;
        logic [2:0] s[4];
        logic [3:0] we;
        int         n;
        for (int k = 0; k < 4; k++) s[k] = 3'b111;
        we         = 4'h0;
        e.set_data = 1'b0;
        e.dval     = '0;
        e.done     = 1'b1;
        e.first    = 1'b1;
        n          = 0;
        case (op)
            3'd1: begin s[rd] = 3'b011; we[rd] = 1'b1; e.set_data = 1'b1; e.dval = imm; end
            3'd2: begin s[rd] = {1'b1, rs}; we[rd] = 1'b1; end
            3'd3: begin
                s[rd] = {1'b1, rs}; s[rs] = {1'b1, rd};
                we[rd] = 1'b1; we[rs] = 1'b1;
            end
            3'd4: begin
                for (int k = 0; k < 4; k++) begin
                    if (k != int'(rs)) begin s[k] = {1'b1, rs}; we[k] = 1'b1; end
                end
            end
            3'd5: n = int'(imm[CNT_W-1:0]);
            3'd6: begin
                for (int k = 0; k < 4; k++) s[k] = 3'b011;
                we = 4'hF; e.set_data = 1'b1; e.dval = 16'h0000;
            end
            default: ;
        endcase
        if (n > 0) begin
            for (int k = 0; k < 4; k++) s[(k + 1) % 4] = {1'b1, 2'(k)};
            e.ctrl = {s[0], s[1], s[2], s[3], 4'hF};
            for (int i = 0; i < n; i++) begin
                e.done  = (i == n - 1);
                e.first = (i == 0);
                sched.push_back(e);
            end
        end else begin
            e.ctrl = {s[0], s[1], s[2], s[3], we};
            sched.push_back(e);
        end
    endtask

    task automatic clearModel();
        sched.delete();
        occ        = 0;
        exp_data   = 16'h0000;
        rot_active = 1'b0;
    endtask

    // One clock: check ready, advance the model across the edge, check outputs.
    task automatic tick();
        entry_t      e;
        bit          acc;
        bit          exp_ready;
        logic [15:0] exp_ctrl;
        bit          exp_done;
        exp_ready = (occ < QDEPTH);
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        acc = cmd_valid && exp_ready;
        @(posedge clk);
        if (sched.size() > 0) begin
            e          = sched.pop_front();
            exp_ctrl   = e.ctrl;
            exp_done   = e.done;
            rot_active = !e.done;
            if (e.first) occ--;
            if (e.set_data) exp_data = e.dval;
        end else begin
            exp_ctrl   = 16'hFFF0;
            exp_done   = 1'b0;
            rot_active = 1'b0;
        end
        if (acc) begin
            expand(cmd_op, cmd_rd, cmd_rs, cmd_imm);
            occ++;
        end
        accepted = acc;
        #1;
        checkOutput("ctrl", 32'(ctrl), 32'(exp_ctrl));
        checkOutput("data", 32'(data), 32'(exp_data));
        checkOutput("done", 32'(done), 32'(exp_done));
        checkOutput("busy", 32'(busy), 32'((occ > 0) || rot_active));
    endtask

    task automatic applyStimulus(input bit v, input logic [2:0] op, input logic [1:0] rd,
                                 input logic [1:0] rs, input logic [15:0] imm);
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_imm   = imm;
    endtask

    // Present a command and hold it until accepted, within a cycle budget.
    task automatic sendCmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                           input logic [15:0] imm);
        applyStimulus(1'b1, op, rd, rs, imm);
        accepted = 1'b0;
        for (int i = 0; i < 64 && !accepted; i++) tick();
        if (!accepted) begin
            checks++;
            errors++;
            $error("[TB] FAIL accept_timeout observed %0d expected %0d", 0, 1);
        end
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 3'd0, 2'd0, 2'd0, 16'h0000);
        repeat (n) tick();
    endtask

    // Asynchronous reset at the current time, then release on a falling edge.
    task automatic assertReset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        #1;
        checkOutput("rst_ctrl", 32'(ctrl), 32'(16'hFFF0));
        checkOutput("rst_data", 32'(data), 32'(16'h0000));
        checkOutput("rst_done", 32'(done), 32'(1'b0));
        checkOutput("rst_busy", 32'(busy), 32'(1'b0));
        checkOutput("rst_ready", 32'(cmd_ready), 32'(1'b0));
        clearModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clearModel();
        #2;
        assertReset();
        $display("[TB] reset released");

        sendCmd(3'd1, 2'd1, 2'd0, 16'h1234);
        idleCycles(3);

        sendCmd(3'd1, 2'd2, 2'd0, 16'h8888);
        sendCmd(3'd3, 2'd1, 2'd2, 16'h0000);
        idleCycles(3);

        // Long ROT fills the queue; the later sends exercise full + pop.
        sendCmd(3'd5, 2'd0, 2'd0, 16'h0003);
        sendCmd(3'd2, 2'd0, 2'd3, 16'h0000);
        sendCmd(3'd1, 2'd3, 2'd0, 16'hABCD);
        sendCmd(3'd6, 2'd0, 2'd0, 16'h5555);
        sendCmd(3'd4, 2'd0, 2'd1, 16'h0000);
        idleCycles(12);

        sendCmd(3'd5, 2'd0, 2'd0, 16'hFFF0);
        sendCmd(3'd7, 2'd2, 2'd1, 16'h1111);
        sendCmd(3'd0, 2'd0, 2'd0, 16'h0000);
        idleCycles(4);

        sendCmd(3'd3, 2'd2, 2'd2, 16'h0000);
        sendCmd(3'd2, 2'd0, 2'd0, 16'h0000);
        sendCmd(3'd5, 2'd0, 2'd0, 16'h0001);
        sendCmd(3'd5, 2'd0, 2'd0, 16'h0002);
        sendCmd(3'd4, 2'd0, 2'd3, 16'h0000);
        idleCycles(6);

        // Reset in the second ROT cycle with two commands still queued.
        sendCmd(3'd5, 2'd0, 2'd0, 16'h0005);
        sendCmd(3'd1, 2'd0, 2'd0, 16'h4242);
        sendCmd(3'd2, 2'd3, 2'd1, 16'h0000);
        #3;
        assertReset();
        idleCycles(5);

        for (int i = 0; i < 150; i++) begin
            sendCmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
            if (i == 75) begin
                #3;
                assertReset();
            end
        end
        idleCycles(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
